// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the IFU (read-only) and the LSU (read/write).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LSU priority with a starvation limit.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_gnt,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned      LAT_W    = 3;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);
  localparam logic             OWN_IFU  = 1'b0;
  localparam logic             OWN_LSU  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             owner_q, owner_d;
  logic             ret;
  logic             arb_ok;
  logic             lsu_win;

`ifdef MEM_ARB_RR_EN
  // On contention the requester that was not granted most recently wins.
  logic last_lsu_q, last_lsu_d;

  always_comb begin
    lsu_win = lsu_req & ~(ifu_req & last_lsu_q);
  end

  always_comb begin
    last_lsu_d = last_lsu_q;
    if (ifu_gnt) begin
      last_lsu_d = 1'b0;
    end else if (lsu_gnt) begin
      last_lsu_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu_q <= 1'b1;
    end else begin
      last_lsu_q <= last_lsu_d;
    end
  end
`else
  // LSU wins unless it has already taken STARVE_LIM contested grants in a row.
  localparam int unsigned         STARVE_W   = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    lsu_win = lsu_req & ~(ifu_req & (starve_cnt_q == STARVE_MAX));
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (ifu_gnt) begin
      starve_cnt_d = '0;
    end else if (lsu_gnt) begin
      if (!ifu_req) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // Next state, grant, memory strobe and read-return steering.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    owner_d    = owner_q;
    ifu_gnt    = 1'b0;
    lsu_gnt    = 1'b0;
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;
    ifu_rdata  = '0;
    lsu_rdata  = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    ret    = (state_q == WAIT) && (lat_cnt_q == LAT_LAST);
    // rst_n gates grants so nothing reaches the memory while reset is held.
    arb_ok = rst_n && ((state_q == IDLE) || ret);

    if (ret) begin
      state_d   = IDLE;
      lat_cnt_d = '0;
      if (owner_q == OWN_LSU) begin
        lsu_rvalid = 1'b1;
        lsu_rdata  = mem_rdata;
      end else begin
        ifu_rvalid = 1'b1;
        ifu_rdata  = mem_rdata;
      end
    end else if (state_q == WAIT) begin
      lat_cnt_d = lat_cnt_q + LAT_W'(1);
    end

    if (arb_ok && lsu_win) begin
      lsu_gnt   = 1'b1;
      mem_en    = 1'b1;
      mem_we    = lsu_we;
      mem_addr  = lsu_addr;
      mem_wdata = lsu_wdata;
      if (!lsu_we) begin
        state_d   = WAIT;
        lat_cnt_d = LAT_W'(1);
        owner_d   = OWN_LSU;
      end
    end else if (arb_ok && ifu_req) begin
      ifu_gnt   = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = ifu_addr;
      state_d   = WAIT;
      lat_cnt_d = LAT_W'(1);
      owner_d   = OWN_IFU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      owner_q   <= OWN_IFU;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
    end
  end

endmodule
